vec_stream_tx: RTL
==================

Name: vec_stream_tx

Overview:
Vector-atomic stream transmitter that feeds a layer's s_valid/s_ready/data_in input port. It accepts elements one at a time from an upstream producer and holds each complete M-element vector in a two-bank ping-pong buffer. It transmits a vector on the m_valid/m_ready interface only once the whole vector is held, so the downstream layer never stalls mid-vector waiting on the producer. It sits between the host/test source and the first layer, or between two layers whose vector lengths match.

Parameters:
T, 16, data width in bits (signed)
M, 8, elements per vector; M >= 2
CW, 16, width of vec_count

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
s_valid  input  1  upstream element valid
s_ready  output  1  block can accept an element
data_in  input  T  upstream element, signed
m_valid  output  1  data_out valid toward layer
m_ready  input  1  layer accepts data_out
data_out  output  T  element to layer, signed
m_last  output  1  data_out is element M-1 of its vector
flush  input  1  synchronous discard of all buffered data
level  output  2  number of complete vectors held (0..2)
vec_count  output  CW  vectors fully transmitted since reset

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- State:
  - Banks 0/1, each holding M x T.
  - full[1:0] flags.
  - wr_bank, wr_idx: write side. rd_bank, rd_idx: read side. Index width is $clog2(M).
- Reset:
  - full=0, wr_bank=rd_bank=0, wr_idx=rd_idx=0, vec_count=0.
  - Outputs: s_ready=1, m_valid=0, m_last=0, data_out=0, level=0.
  - Bank contents are don't-care.
  - Reset mid-vector discards everything, on both the input and output sides.
- Combinational outputs:
  - s_ready = !full[wr_bank].
  - m_valid = full[rd_bank].
  - data_out = bank[rd_bank][rd_idx] when m_valid, else 0.
  - m_last = m_valid && rd_idx==M-1.
  - level = full[0]+full[1].
- Load (s_valid && s_ready):
  - Write data_in into bank[wr_bank][wr_idx].
  - If wr_idx==M-1: set full[wr_bank], toggle wr_bank, wr_idx<=0.
  - Otherwise wr_idx<=wr_idx+1.
- Transmit (m_valid && m_ready):
  - If rd_idx==M-1: clear full[rd_bank], toggle rd_bank, rd_idx<=0, vec_count<=vec_count+1.
  - Otherwise rd_idx<=rd_idx+1.
- Latency: last element of a vector accepted at edge t -> m_valid=1 in the cycle after edge t, provided no earlier vector is pending.
- Sustained throughput: 1 element/cycle. The producer fills one bank while the layer drains the other.
- Handshake rules:
  - Once asserted, m_valid stays high and data_out/m_last stay stable until m_ready is sampled high.
  - s_ready may deassert without s_valid (it depends only on buffer state).
  - No combinational path from m_ready to s_ready.
- Boundaries:
  - Both banks full: s_ready=0 and s_valid is ignored.
  - Simultaneous fill-complete on one bank and drain-complete on the other in the same cycle: both flag updates take effect, level stays unchanged.
  - With one bank full and the other empty, s_ready stays 1 while draining.
  - vec_count wraps from 2^CW-1 to 0.
- flush:
  - Same effect as reset except vec_count is preserved.
  - flush has priority over any load or transmit handshake in the same cycle; that element is dropped and vec_count is not incremented.
  - Partially filled vectors are discarded.
- Arithmetic: data is passed through bit-exact; no sign extension or saturation.

Decomposition:
- Shared package stream_pkg holds:
  - localparam defaults T=16, M=8.
  - typedef logic signed [T-1:0] elem_t.
  - Index typedef logic [$clog2(M)-1:0] idx_t.
- One sub-module, vec_bank: M-entry register array with a synchronous write port (wr_en, wr_addr, wr_data) and a combinational read port. Instantiate it twice.
- Control (flags, pointers, counter) stays in vec_stream_tx.

Test Plan:
- Reset, then stream 1..8 with s_valid held high and m_ready=1 -> m_valid rises the cycle after 8 is accepted; data_out emits 1..8; m_last=1 only on 8; vec_count=1; level returns to 0.
- m_ready=0 while loading 16 elements (1..16) -> s_ready drops after 16 is accepted; level=2; the 17th s_valid is not accepted. Release m_ready -> outputs 1..16 in order; vec_count=2.
- Continuous 5 vectors, s_valid=1 and m_ready=1 every cycle -> zero bubbles on output after the first vector; vec_count=5; the cycle where bank A fills while bank B drains shows level unchanged.
- Random m_ready toggling during transmission of 100..107 -> data_out and m_last stable whenever m_valid=1 and m_ready=0; sequence unchanged.
- Load 3 elements, assert flush in the same cycle as an s_valid handshake of value 4 -> element 4 dropped, level=0, s_ready=1. Then load 1..8 -> output 1..8 with no stale 1..3; vec_count unaffected.
- Preload vec_count to 65535 via 65535 vectors (or force) and send one more vector -> vec_count wraps to 0. Assert reset mid-transmit at rd_idx=3 -> m_valid=0, level=0, vec_count=0 the next cycle.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and defaults for the vector stream transmitter.
package stream_pkg;

    localparam int T_DEFAULT = 16;
    localparam int M_DEFAULT = 8;

    typedef logic signed [T_DEFAULT-1:0]  elem_t;
    typedef logic [$clog2(M_DEFAULT)-1:0] idx_t;

    // Number of banks currently holding a complete vector.
    function automatic logic [1:0] count_full(input logic [1:0] full);
        return {1'b0, full[0]} + {1'b0, full[1]};
    endfunction

endpackage

// File: rtl/vec_stream_tx_if.sv
// Element handshake bundle: upstream (s_*) side and layer-facing (m_*) side.
interface vec_stream_tx_if
    import stream_pkg::*;
#(
    parameter int T = T_DEFAULT
);

    logic                s_valid;
    logic                s_ready;
    logic signed [T-1:0] data_in;
    logic                m_valid;
    logic                m_ready;
    logic signed [T-1:0] data_out;
    logic                m_last;

    // Producer and layer seen as one environment driving the transmitter.
    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, m_last
    );

    // The transmitter itself.
    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, m_last
    );

endinterface

// File: rtl/vec_bank.sv
// One vector bank: M registers, synchronous write port, combinational read port.
// Contents are not reset; validity is tracked by the owner's full flags.
module vec_bank
    import stream_pkg::*;
#(
    parameter int T  = T_DEFAULT,
    parameter int M  = M_DEFAULT,
    localparam int IW = $clog2(M)
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [IW-1:0]       i_wr_addr,
    input  logic signed [T-1:0] i_wr_data,
    input  logic [IW-1:0]       i_rd_addr,
    output logic signed [T-1:0] o_rd_data
);

    logic signed [T-1:0] r_mem [M];

    // Store one element per write strobe.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/vec_stream_tx.sv
// Vector-atomic ping-pong transmitter. A vector is only offered to the layer
// once all M elements are held, so the layer never stalls mid-vector on the
// producer. One bank fills while the other drains for 1 element/cycle.
module vec_stream_tx
    import stream_pkg::*;
#(
    parameter int T  = T_DEFAULT,
    parameter int M  = M_DEFAULT,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    vec_stream_tx_if.slave  bus,
    output logic [1:0]      level,
    output logic [CW-1:0]   vec_count
);

    localparam int            IW       = $clog2(M);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [IW-1:0]       r_wr_idx;
    logic [IW-1:0]       r_rd_idx;
    logic [CW-1:0]       r_vec_count;

    logic                w_s_ready;
    logic                w_m_valid;
    logic                w_load;
    logic                w_xmit;
    logic                w_fill_done;
    logic                w_drain_done;
    logic [1:0]          w_set;
    logic [1:0]          w_clr;
    logic                w_wr_en0;
    logic                w_wr_en1;
    logic signed [T-1:0] w_rd_data0;
    logic signed [T-1:0] w_rd_data1;
    logic signed [T-1:0] w_rd_sel;

    // The write bank is only ever full when both banks are full, and the
    // read bank is only empty when nothing is held, so these two flags alone
    // give the handshake readiness. Neither depends on m_ready.
    assign w_s_ready = !r_full[r_wr_bank];
    assign w_m_valid = r_full[r_rd_bank];

    assign w_load       = bus.s_valid && w_s_ready;
    assign w_xmit       = w_m_valid && bus.m_ready;
    assign w_fill_done  = w_load && (r_wr_idx == LAST_IDX);
    assign w_drain_done = w_xmit && (r_rd_idx == LAST_IDX);

    // Fill and drain always target different banks, so set and clear never
    // collide and both take effect when they coincide.
    assign w_set = w_fill_done  ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr = w_drain_done ? (2'b01 << r_rd_bank) : 2'b00;

    // A flushed or reset cycle must not leave a stray element behind.
    assign w_wr_en0 = w_load && !reset && !flush && (r_wr_bank == 1'b0);
    assign w_wr_en1 = w_load && !reset && !flush && (r_wr_bank == 1'b1);

    vec_bank #(.T(T), .M(M)) u_bank0 (
        .clk       (clk),
        .i_wr_en   (w_wr_en0),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (bus.data_in),
        .i_rd_addr (r_rd_idx),
        .o_rd_data (w_rd_data0)
    );

    vec_bank #(.T(T), .M(M)) u_bank1 (
        .clk       (clk),
        .i_wr_en   (w_wr_en1),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (bus.data_in),
        .i_rd_addr (r_rd_idx),
        .o_rd_data (w_rd_data1)
    );

    // Bank full flags: discarded by reset or flush, otherwise set on fill
    // completion and cleared on drain completion.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
        end
    end

    // Write pointer: advance per accepted element, swap banks after M.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else if (w_load) begin
            if (w_fill_done) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_idx  <= '0;
            end else begin
                r_wr_idx  <= r_wr_idx + 1'b1;
            end
        end
    end

    // Read pointer: advance per transmitted element, swap banks after M.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
        end else if (w_xmit) begin
            if (w_drain_done) begin
                r_rd_bank <= ~r_rd_bank;
                r_rd_idx  <= '0;
            end else begin
                r_rd_idx  <= r_rd_idx + 1'b1;
            end
        end
    end

    // Completed-vector counter; survives flush, wraps naturally at 2^CW.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec_count <= '0;
        end else if (!flush && w_drain_done) begin
            r_vec_count <= r_vec_count + 1'b1;
        end
    end

    assign w_rd_sel = r_rd_bank ? w_rd_data1 : w_rd_data0;

    assign bus.s_ready  = w_s_ready;
    assign bus.m_valid  = w_m_valid;
    assign bus.data_out = w_m_valid ? w_rd_sel : '0;
    assign bus.m_last   = w_m_valid && (r_rd_idx == LAST_IDX);

    assign level     = count_full(r_full);
    assign vec_count = r_vec_count;

endmodule
